// File: rtl/ram_port_master.sv
// ram_port_master: burst initiator for one port of a synchronous RAM
// with a 1-cycle registered read. Handles write bursts, credit-limited read bursts and a 4-entry return FIFO.
module ram_port_master #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_cur_adr;
    logic [LW-1:0] r_left;

    logic          r_ram_ce;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_adr;
    logic [DW-1:0] r_ram_din;

    // r_s2: RAM data for an earlier read is on ram_dout this cycle
    logic          r_s2;

    logic [DW-1:0] r_fifo [4];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_count;

    logic          w_cmd_hs;
    logic          w_wr_hs;
    logic          w_s1;
    logic [3:0]    w_inflight;
    logic          w_credit;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_last;

    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_WRITE);

    assign w_cmd_hs  = cmd_valid & cmd_ready;
    assign w_wr_hs   = wr_valid & wr_ready;
    assign w_last    = (r_left == '0);

    // s1: a read is on the RAM pins this cycle
    assign w_s1      = r_ram_ce & ~r_ram_we;

    // Every read in flight or buffered holds one FIFO slot, so the
    // FIFO can never be asked to take a fifth entry.
    assign w_inflight = {1'b0, r_count} + {3'b000, w_s1} + {3'b000, r_s2};
    assign w_credit   = (w_inflight < 4'd4);
    assign w_issue    = (r_state == S_READ) & w_credit;

    assign w_push    = r_s2;
    assign w_pop     = rd_valid & rd_ready;

    assign rd_valid  = (r_count != 3'd0);
    assign rd_data   = rd_valid ? r_fifo[r_rptr] : '0;
    assign busy      = (r_state != S_IDLE) | rd_valid;

    assign ram_ce    = r_ram_ce;
    assign ram_we    = r_ram_we;
    assign ram_adr   = r_ram_adr;
    assign ram_din   = r_ram_din;

    // Burst sequencer: command latch, beat countdown, state changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur_adr <= '0;
            r_left    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cur_adr <= cmd_adr;
                        r_left    <= cmd_len;
                        r_state   <= cmd_we ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_wr_hs) begin
                        r_cur_adr <= r_cur_adr + AW'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_left <= r_left - LW'(1);
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_cur_adr <= r_cur_adr + AW'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_left <= r_left - LW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_s1 && !r_s2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM pin registers; address and data hold while the port is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_ce  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_ram_adr <= '0;
            r_ram_din <= '0;
        end else begin
            r_ram_ce <= w_wr_hs | w_issue;
            r_ram_we <= w_wr_hs;
            if (w_wr_hs) begin
                r_ram_adr <= r_cur_adr;
                r_ram_din <= wr_data;
            end else if (w_issue) begin
                r_ram_adr <= r_cur_adr;
            end
        end
    end

    // Read return tracker: RAM data is valid the cycle after a read cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2 <= 1'b0;
        end else begin
            r_s2 <= w_s1;
        end
    end

    // Return FIFO storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= ram_dout;
        end
    end

    // Return FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
